time_up_screen_ctrl: RTL and testbench
======================================

// Module: time_up_screen_ctrl
// PURPOSE
// - Game-clock controller for the end-of-round "TIME / IS / UP" text overlay.
// - Counts down the round in whole seconds and sequences IDLE -> RUNNING -> TIMEUP.
// - In TIMEUP it blinks the overlay.
// - For each VGA (row,col) it outputs the glyph letter code and the glyph pixel index
//   used to address the shared 50x50 letter ROM, plus an overlay enable.
// - Sits between the VGA timing generator and the letter ROM / colour mux.
// PARAMETERS
// - CLK_HZ        50_000_000  clk cycles per second tick; >=2
// - GAME_SECONDS  120         round length in seconds; 1..255
// - BLINK_HALF    12_500_000  clk cycles per blink half-period; >=1
// PORTS
// - clk         in   1   system clock, all state on posedge
// - resetn      in   1   asynchronous, active-low reset
// - start       in   1   level; begin round (sampled in IDLE only)
// - pause       in   1   level; freeze countdown while high (RUNNING only)
// - ack         in   1   level; dismiss overlay (sampled in TIMEUP only)
// - row         in   9   current VGA row
// - col         in   10  current VGA column
// - letter      out  5   letter code, A=0..Z=25; 31 = blank
// - pixel       out  13  glyph pixel index 0..2499 = (row-rbase)*50 + (col-cbase)
// - overlay_en  out  1   high when this pixel belongs to a visible overlay glyph
// - time_left   out  8   seconds remaining
// - time_up     out  1   one-cycle pulse on RUNNING->TIMEUP
// - state       out  2   00 IDLE, 01 RUNNING, 10 TIMEUP (11 unused; decodes to IDLE)
// BEHAVIOUR
// - Reset (resetn=0, async):
//   - state=IDLE, time_left=GAME_SECONDS, prescaler=0, blink_cnt=0, blink_on=1.
//   - letter=31, pixel=0, overlay_en=0, time_up=0.
// - IDLE:
//   - start=1 -> RUNNING next cycle; prescaler cleared, time_left=GAME_SECONDS.
// - RUNNING:
//   - Prescaler counts 0..CLK_HZ-1 while pause=0 and holds while pause=1.
//   - A tick fires on the cycle the prescaler wraps CLK_HZ-1 -> 0.
//   - Tick with time_left>1: decrement time_left.
//   - Tick with time_left==1: time_left=0, state=TIMEUP, time_up=1 for exactly that one
//     cycle, blink_cnt=0, blink_on=1.
//   - start is ignored.
//   - ack is ignored.
// - TIMEUP:
//   - blink_cnt counts 0..BLINK_HALF-1; on wrap, blink_on toggles.
//   - ack=1 -> IDLE next cycle, time_left reloads GAME_SECONDS.
//   - ack and start both high: ack wins; start is not seen until a later cycle in IDLE.
//   - pause is ignored.
// - Glyph map:
//   - line 1, rows 190..239, rbase 190: T(19) col 170..219, I(8) 220..269, M(12) 270..319,
//     E(4) 320..369.
//   - line 2, rows 240..289, rbase 240: I(8) col 220..269, S(18) 270..319.
//   - line 3, rows 290..339, rbase 290: U(20) col 220..269, P(15) 270..319.
//   - cbase is the first column of each cell.
//   - pixel is computed combinationally from the bases. There is no running counter, so
//     there is no drift across lines.
// - Pixel path latency:
//   - letter, pixel and overlay_en are registered, 1 clk after row/col.
//   - Outside every cell: letter=31, pixel=0, overlay_en=0.
//   - Inside a cell: letter and pixel are valid in every state.
//   - overlay_en = inside cell & state==TIMEUP & blink_on.
// - Width rules:
//   - (row-rbase) is 0..49 and (col-cbase) is 0..49; compute the product at 13 bits; max
//     index is 2499.
//   - time_left never underflows below 0.
// - Mid-operation reset:
//   - Any state returns to IDLE at once.
//   - overlay_en drops asynchronously.
// TESTING  (CLK_HZ=10, GAME_SECONDS=3, BLINK_HALF=4)
// - Countdown:
//   - reset, then start=1 for 1 cycle -> state=01.
//   - time_left reads 3,2,1 after 10,20 cycles.
//   - At 30 cycles: time_left=0, state=10, time_up high exactly 1 cycle.
// - Pause:
//   - pause=1 for 25 cycles mid-round -> time_left and the prescaler frozen.
//   - Expiry is delayed by exactly 25 cycles.
// - Glyph map, one clock after each drive:
//   - row=190, col=170 -> letter=19, pixel=0.
//   - row=239, col=369 -> letter=4, pixel=2499.
//   - row=265, col=300 -> letter=18, pixel=1280.
//   - row=300, col=219 -> letter=31, overlay_en=0.
// - Blink: in TIMEUP with (row,col) inside a cell -> overlay_en pattern is 4 high, 4 low,
//   4 high.
// - Ack/start priority: ack=1 and start=1 together in TIMEUP.
//   - Next cycle: state=00, time_left=3.
//   - start held -> state=01 the following cycle.
// - Async reset: assert resetn=0 mid-TIMEUP, between clock edges.
//   - overlay_en=0 and state=00 immediately.
//   - letter=31 immediately.

Source files
------------

// File: rtl/time_up_screen_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : time_up_screen_ctrl_if                                       |
// | Description : Control, status and VGA pixel-path signals of the            |
// |               end-of-round "TIME / IS / UP" overlay controller.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface time_up_screen_ctrl_if;
  // Round control inputs (levels)
  logic        start;
  logic        pause;
  logic        ack;
  // VGA scan position
  logic [8:0]  row;
  logic [9:0]  col;
  // Glyph addressing towards the letter ROM / colour mux
  logic [4:0]  letter;
  logic [12:0] pixel;
  logic        overlay_en;
  // Game-clock status
  logic [7:0]  time_left;
  logic        time_up;
  logic [1:0]  state;

  // Driver side: game logic and VGA timing generator
  modport master (
    output start, pause, ack, row, col,
    input  letter, pixel, overlay_en, time_left, time_up, state
  );

  // Controller side
  modport slave (
    input  start, pause, ack, row, col,
    output letter, pixel, overlay_en, time_left, time_up, state
  );
endinterface
`default_nettype wire

// File: rtl/time_up_screen_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : time_up_screen_ctrl                                          |
// | Description : Round countdown (IDLE -> RUNNING -> TIMEUP), blinking        |
// |               "TIME / IS / UP" overlay and 50x50 glyph ROM addressing.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module time_up_screen_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = 120,
  parameter int BLINK_HALF   = 12_500_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  time_up_screen_ctrl_if.slave  bus
);

  localparam int c_presc_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [c_presc_w-1:0] c_presc_max  = c_presc_w'(CLK_HZ - 1);
  localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
  localparam logic [c_blink_w-1:0] c_blink_max  = c_blink_w'(BLINK_HALF - 1);
  localparam logic [c_blink_w-1:0] c_blink_one  = c_blink_w'(1);
  localparam logic [7:0]           c_game_secs  = 8'(GAME_SECONDS);
  localparam logic [4:0]           c_blank      = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_TIMEUP  = 2'b10
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_time_left;
  logic [c_presc_w-1:0]   r_prescaler;
  logic [c_blink_w-1:0]   r_blink_cnt;
  logic                   r_blink_on;
  logic                   r_time_up;

  logic [4:0]             r_letter;
  logic [12:0]            r_pixel;
  logic                   r_overlay_en;

  logic                   w_inside;
  logic [4:0]             w_letter;
  logic [8:0]             w_rbase;
  logic [9:0]             w_cbase;
  logic [12:0]            w_pixel;

  // Round sequencer: countdown prescaler, expiry pulse and blink timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_time_left <= c_game_secs;
      r_prescaler <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_time_up   <= 1'b0;
    end else begin
      r_time_up <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_RUNNING;
            r_prescaler <= '0;
            r_time_left <= c_game_secs;
          end
        end
        S_RUNNING: begin
          // A high pause freezes the prescaler, which also freezes time_left
          if (!bus.pause) begin
            if (r_prescaler == c_presc_max) begin
              r_prescaler <= '0;
              if (r_time_left > 8'd1) begin
                r_time_left <= r_time_left - 8'd1;
              end else begin
                r_time_left <= 8'd0;
                r_state     <= S_TIMEUP;
                r_time_up   <= 1'b1;
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
              end
            end else begin
              r_prescaler <= r_prescaler + c_presc_one;
            end
          end
        end
        S_TIMEUP: begin
          if (r_blink_cnt == c_blink_max) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
          end else begin
            r_blink_cnt <= r_blink_cnt + c_blink_one;
          end
          // ack takes priority; start is only looked at once back in IDLE
          if (bus.ack) begin
            r_state     <= S_IDLE;
            r_time_left <= c_game_secs;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Glyph map: locate the cell under (row,col) and its top-left corner
  always_comb begin
    w_inside = 1'b0;
    w_letter = c_blank;
    w_rbase  = 9'd0;
    w_cbase  = 10'd0;
    if (bus.row >= 9'd190 && bus.row <= 9'd239) begin
      w_rbase = 9'd190;
      if (bus.col >= 10'd170 && bus.col <= 10'd369) begin
        w_inside = 1'b1;
        if (bus.col <= 10'd219) begin
          w_letter = 5'd19;  w_cbase = 10'd170;   // T
        end else if (bus.col <= 10'd269) begin
          w_letter = 5'd8;   w_cbase = 10'd220;   // I
        end else if (bus.col <= 10'd319) begin
          w_letter = 5'd12;  w_cbase = 10'd270;   // M
        end else begin
          w_letter = 5'd4;   w_cbase = 10'd320;   // E
        end
      end
    end else if (bus.row >= 9'd240 && bus.row <= 9'd289) begin
      w_rbase = 9'd240;
      if (bus.col >= 10'd220 && bus.col <= 10'd319) begin
        w_inside = 1'b1;
        if (bus.col <= 10'd269) begin
          w_letter = 5'd8;   w_cbase = 10'd220;   // I
        end else begin
          w_letter = 5'd18;  w_cbase = 10'd270;   // S
        end
      end
    end else if (bus.row >= 9'd290 && bus.row <= 9'd339) begin
      w_rbase = 9'd290;
      if (bus.col >= 10'd220 && bus.col <= 10'd319) begin
        w_inside = 1'b1;
        if (bus.col <= 10'd269) begin
          w_letter = 5'd20;  w_cbase = 10'd220;   // U
        end else begin
          w_letter = 5'd15;  w_cbase = 10'd270;   // P
        end
      end
    end
  end

  // Index is rebuilt from the cell bases each pixel, so it cannot drift
  assign w_pixel = w_inside
                 ? (({4'd0, bus.row} - {4'd0, w_rbase}) * 13'd50
                    + ({3'd0, bus.col} - {3'd0, w_cbase}))
                 : 13'd0;

  // Pixel path register: one clock behind row/col, cleared at once by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_letter     <= c_blank;
      r_pixel      <= 13'd0;
      r_overlay_en <= 1'b0;
    end else begin
      r_letter     <= w_letter;
      r_pixel      <= w_pixel;
      r_overlay_en <= w_inside & (r_state == S_TIMEUP) & r_blink_on;
    end
  end

  assign bus.letter     = r_letter;
  assign bus.pixel      = r_pixel;
  assign bus.overlay_en = r_overlay_en;
  assign bus.time_left  = r_time_left;
  assign bus.time_up    = r_time_up;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_time_up_screen_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_time_up_screen_ctrl                                       |
// | Description : Self-checking bench for time_up_screen_ctrl with a           |
// |               cycle-count reference model of the round and glyph map.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_time_up_screen_ctrl;
  localparam int CLK_HZ       = 10;
  localparam int GAME_SECONDS = 3;
  localparam int BLINK_HALF   = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  time_up_screen_ctrl_if bus ();

  time_up_screen_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .GAME_SECONDS (GAME_SECONDS),
    .BLINK_HALF   (BLINK_HALF)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Overlay cells: top row, left column, letter code
  int cell_rb [8] = '{190, 190, 190, 190, 240, 240, 290, 290};
  int cell_cb [8] = '{170, 220, 270, 320, 220, 270, 220, 270};
  int cell_lt [8] = '{ 19,   8,  12,   4,   8,  18,  20,  15};

  // Reference model: 0 idle, 1 running, 2 time-up
  int   m_state;
  int   m_n;          // unpaused cycles since the round started
  int   m_k;          // cycles spent in time-up
  logic m_time_up;
  int   exp_letter;
  int   exp_pixel;
  logic exp_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void glyph_ref(input int r, input int c,
                                    output int lt, output int px, output bit in_cell);
    lt = 31; px = 0; in_cell = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (r >= cell_rb[i] && r < cell_rb[i] + 50 && c >= cell_cb[i] && c < cell_cb[i] + 50) begin
        lt      = cell_lt[i];
        px      = (r - cell_rb[i]) * 50 + (c - cell_cb[i]);
        in_cell = 1'b1;
      end
    end
  endfunction

  function automatic bit blink_ref(input int k);
    return ((k / BLINK_HALF) % 2) == 0;
  endfunction

  function automatic int tl_ref();
    if (m_state == 1) return GAME_SECONDS - m_n / CLK_HZ;
    if (m_state == 2) return 0;
    return GAME_SECONDS;
  endfunction

  task automatic model_reset();
    m_state = 0; m_n = 0; m_k = 0; m_time_up = 1'b0;
    exp_letter = 31; exp_pixel = 0; exp_ov = 1'b0;
  endtask

  task automatic model_edge();
    int lt, px;
    bit inc;
    if (!resetn) begin
      model_reset();
      return;
    end
    glyph_ref(int'(bus.row), int'(bus.col), lt, px, inc);
    exp_letter = lt;
    exp_pixel  = px;
    exp_ov     = inc && (m_state == 2) && blink_ref(m_k);
    m_time_up  = 1'b0;
    case (m_state)
      0: if (bus.start) begin m_state = 1; m_n = 0; end
      1: if (!bus.pause) begin
           m_n++;
           if (m_n == GAME_SECONDS * CLK_HZ) begin
             m_state = 2; m_time_up = 1'b1; m_k = 0;
           end
         end
      default: begin
        m_k++;
        if (bus.ack) m_state = 0;
      end
    endcase
  endtask

  task automatic check_all();
    chk("state",      bus.state,      m_state);
    chk("time_left",  bus.time_left,  tl_ref());
    chk("time_up",    bus.time_up,    m_time_up);
    chk("letter",     bus.letter,     exp_letter);
    chk("pixel",      bus.pixel,      exp_pixel);
    chk("overlay_en", bus.overlay_en, exp_ov);
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_rc(output int r, output int c);
    int i;
    if ($urandom_range(1, 0) == 1) begin
      i = $urandom_range(7, 0);
      r = cell_rb[i] + $urandom_range(49, 0);
      c = cell_cb[i] + $urandom_range(49, 0);
    end else begin
      r = $urandom_range(511, 0);
      c = $urandom_range(1023, 0);
    end
  endtask

  initial begin
    int cyc;
    bit found;
    int r, c;
    logic [11:0] pat;

    bus.start = 1'b0; bus.pause = 1'b0; bus.ack = 1'b0;
    bus.row = 9'd0;   bus.col = 10'd0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_letter", bus.letter, 31);
    resetn = 1'b1;
    step();

    // Countdown: 3,2,1 then expiry 30 cycles after the start edge
    bus.start = 1'b1;
    step();
    chk("run_state", bus.state, 1);
    bus.start = 1'b0;
    found = 1'b0; cyc = 0;
    for (int i = 1; i <= 100 && !found; i++) begin
      rand_rc(r, c); bus.row = 9'(r); bus.col = 10'(c);
      step();
      if (i == 10) chk("tl_after_10", bus.time_left, 2);
      if (i == 20) chk("tl_after_20", bus.time_left, 1);
      if (bus.time_up === 1'b1) begin found = 1'b1; cyc = i; end
    end
    chk("expiry_cycle", cyc, 30);
    chk("expiry_state", bus.state, 2);

    // Blink pattern inside the T cell
    bus.row = 9'd200; bus.col = 10'd180;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      pat = {pat[10:0], bus.overlay_en};
    end
    chk("blink_pattern", pat, 12'hF0F);

    // Glyph map corners
    bus.row = 9'd190; bus.col = 10'd170; step();
    chk("glyph_T_letter", bus.letter, 19);  chk("glyph_T_pixel", bus.pixel, 0);
    bus.row = 9'd239; bus.col = 10'd369; step();
    chk("glyph_E_letter", bus.letter, 4);   chk("glyph_E_pixel", bus.pixel, 2499);
    bus.row = 9'd265; bus.col = 10'd300; step();
    chk("glyph_S_letter", bus.letter, 18);  chk("glyph_S_pixel", bus.pixel, 1280);
    bus.row = 9'd300; bus.col = 10'd219; step();
    chk("glyph_out_letter", bus.letter, 31); chk("glyph_out_ov", bus.overlay_en, 0);

    // ack beats start; held start is seen the cycle after
    bus.ack = 1'b1; bus.start = 1'b1;
    step();
    chk("ack_state", bus.state, 0);
    chk("ack_time_left", bus.time_left, 3);
    bus.ack = 1'b0;
    step();
    chk("restart_state", bus.state, 1);
    bus.start = 1'b0;

    // Pause for 25 cycles mid-round delays expiry by exactly 25
    found = 1'b0; cyc = 0;
    for (int i = 1; i <= 150 && !found; i++) begin
      bus.pause = (i >= 13 && i <= 37);
      rand_rc(r, c); bus.row = 9'(r); bus.col = 10'(c);
      step();
      if (bus.time_up === 1'b1) begin found = 1'b1; cyc = i; end
    end
    chk("paused_expiry_cycle", cyc, 55);
    bus.pause = 1'b0;

    // Asynchronous reset between edges while the overlay is lit
    bus.row = 9'd300; bus.col = 10'd240;
    step();
    chk("pre_reset_ov", bus.overlay_en, 1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("areset_ov",        bus.overlay_en, 0);
    chk("areset_state",     bus.state,      0);
    chk("areset_letter",    bus.letter,     31);
    chk("areset_pixel",     bus.pixel,      0);
    chk("areset_time_left", bus.time_left,  3);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Randomised control and scan traffic
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(7, 0) == 0);
      bus.pause = ($urandom_range(3, 0) == 0);
      bus.ack   = ($urandom_range(5, 0) == 0);
      rand_rc(r, c); bus.row = 9'(r); bus.col = 10'(c);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
